nn_neuron_seq: RTL
==================

// Module: nn_neuron_seq
// PURPOSE
//  Parametrised sequential neural-net layer engine and successor to the fixed 3x3/8-bit NeuralNet.
//  Accepts an image of N_PIX unsigned pixels over a valid/ready handshake and computes
//  N_NEUR neurons. Each neuron is a bias plus a dot product with programmable weights,
//  followed by a shift, an activation and saturation.
//  Uses one shared MAC per cycle. Sits between the image source and the classifier/scoreboard.
// PARAMETERS
//  N_PIX   9  pixels per image
//  PIX_W   8  pixel width, unsigned
//  N_NEUR  1  output neurons (channels)
//  W_W     8  weight/bias width, signed two's complement
//  OUT_W   8  per-neuron result width
//  SHIFT   0  arithmetic right shift applied to the accumulator before activation
//  RELU    1  1: ReLU, unsigned saturate to [0, 2^OUT_W-1]
//             0: signed saturate to [-2^(OUT_W-1), 2^(OUT_W-1)-1]
//  (derived) ACC_W = PIX_W+W_W+$clog2(N_PIX)+2
//  (derived) WA_W  = $clog2(N_NEUR*(N_PIX+1))
// PORTS
//  clk         in   1              clock; all logic on rising edge
//  rst         in   1              synchronous, active-high reset
//  in_valid    in   1              image valid
//  in_ready    out  1              engine can accept an image
//  InputImage  in   N_PIX*PIX_W    pixel p = bits [p*PIX_W +: PIX_W]
//  w_we        in   1              weight/bias write strobe
//  w_addr      in   WA_W           weight address n*N_PIX+p; bias address N_NEUR*N_PIX+n
//  w_data      in   W_W            signed weight/bias value
//  cfg_err     out  1              one-cycle pulse: write rejected
//  out_valid   out  1              result valid
//  out_ready   in   1              consumer accepts result
//  result      out  N_NEUR*OUT_W   neuron n = bits [n*OUT_W +: OUT_W]
// BEHAVIOUR
//  Reset (sync, rst=1 at an edge)
//   - state=IDLE; all weights and biases=0; accumulator, indices and result=0.
//   - out_valid=0, cfg_err=0, in_ready=1 from the cycle after the reset edge.
//   - Reset mid-operation aborts the computation; no result is produced.
//  FSM
//   - IDLE: in_ready=1. in_valid&&in_ready captures InputImage, sets acc=sext(bias[0]) and n=p=0, moves to MAC.
//   - MAC: in_ready=0. Each cycle acc += zext(pix[p])*w[n][p], full ACC_W precision, no overflow.
//     At p==N_PIX-1 the finished sum (acc+prod) is shifted (>>>SHIFT), activated, saturated and stored in slot n.
//     If n<N_NEUR-1: n++, p=0, acc=sext(bias[n+1]). Otherwise move to DONE.
//   - DONE: out_valid=1, result held stable, in_ready=0. out_valid&&out_ready returns to IDLE;
//     out_valid drops the next cycle.
//  Timing
//   - Latency: out_valid is high after exactly K=N_NEUR*N_PIX edges following the accepting edge.
//     The default is 9.
//   - No same-cycle accept in DONE; one IDLE bubble minimum between images.
//   - Max throughput is 1 image per K+2 cycles.
//  Configuration writes
//   - A write with w_we=1 in IDLE and w_addr < N_NEUR*(N_PIX+1) updates the entry at the edge.
//     It affects the next accepted image. An accept and a write in the same cycle: the write applies after that image.
//   - A write in MAC/DONE, or to an out-of-range address, is ignored; cfg_err pulses high for the next cycle.
//  Data rules
//   - The captured image is used, so InputImage may change after the accept.
//   - result keeps its last value after leaving DONE until the next store.
//   - in_valid held high in MAC/DONE is not consumed until IDLE.
// TESTING
//  1 Reset: rst 2 cycles -> in_ready=1, out_valid=0, result=0, cfg_err=0.
//  2 All w=1, bias=0, pixels=10 -> out_valid after 9 edges, result=90.
//  3 All w=127, pixels=255, bias=0 -> result=255 (saturated).
//    Same with RELU=0 -> result=127.
//  4 All w=-1, pixels=5, bias=3 -> result=0 (ReLU). With RELU=0 -> result=-42 (8'hD6).
//  5 Backpressure: hold out_ready=0 for 5 cycles -> result stable, in_ready=0.
//    Write w_addr=0 during MAC -> cfg_err pulse, next image uses the old weight.
//  6 rst at 4th MAC cycle -> out_valid never rises, in_ready=1 next cycle, all weights read back as 0
//    (next image with pixels=10 -> result=0).

Source files
------------

// File: rtl/nn_neuron_seq.sv
// rtl/nn_neuron_seq.sv - sequential neuron layer engine with one shared MAC
module nn_neuron_seq #(
  parameter int N_PIX  = 9,
  parameter int PIX_W  = 8,
  parameter int N_NEUR = 1,
  parameter int W_W    = 8,
  parameter int OUT_W  = 8,
  parameter int SHIFT  = 0,
  parameter int RELU   = 1,
  localparam int ACC_W = PIX_W + W_W + $clog2(N_PIX) + 2,
  localparam int WA_W  = $clog2(N_NEUR * (N_PIX + 1))
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [N_PIX*PIX_W-1:0]    InputImage,
  input  logic                      w_we,
  input  logic [WA_W-1:0]           w_addr,
  input  logic [W_W-1:0]            w_data,
  output logic                      cfg_err,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [N_NEUR*OUT_W-1:0]   result
);

  // Table layout: all weights first (n*N_PIX+p), then one bias per neuron.
  localparam int N_W    = N_NEUR * N_PIX;
  localparam int N_TOT  = N_NEUR * (N_PIX + 1);
  localparam int PW     = (N_PIX > 1) ? $clog2(N_PIX) : 1;
  localparam int NW     = (N_NEUR > 1) ? $clog2(N_NEUR) : 1;
  localparam int PROD_W = PIX_W + W_W + 1;

  // Clamp window after the shift; with ReLU the low bound is zero.
  localparam logic signed [ACC_W-1:0] SAT_HI = (RELU != 0) ?
      ACC_W'((64'sd1 <<< OUT_W) - 64'sd1) :
      ACC_W'((64'sd1 <<< (OUT_W - 1)) - 64'sd1);
  localparam logic signed [ACC_W-1:0] SAT_LO = (RELU != 0) ?
      ACC_W'(64'sd0) :
      ACC_W'(-(64'sd1 <<< (OUT_W - 1)));

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MAC  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Control and datapath state
  state_t                       r_state;
  logic [N_PIX*PIX_W-1:0]       r_img;
  logic signed [ACC_W-1:0]      r_acc;
  logic [NW-1:0]                r_n;
  logic [PW-1:0]                r_p;
  logic [N_NEUR*OUT_W-1:0]      r_res;
  logic                         r_in_ready;
  logic                         r_out_valid;

  // Coefficient table and configuration side
  logic signed [W_W-1:0]        r_w [N_TOT];
  logic                         r_cfg_err;
  logic                         r_pend_v;
  logic [WA_W-1:0]              r_pend_addr;
  logic signed [W_W-1:0]        r_pend_data;

  // Combinational helpers
  logic                         w_accept;
  logic                         w_release;
  logic                         w_addr_ok;
  logic                         w_last_p;
  logic                         w_last_n;
  logic [WA_W-1:0]              w_widx;
  logic [WA_W-1:0]              w_bidx0;
  logic [WA_W-1:0]              w_bidx_next;
  logic [PIX_W-1:0]             w_pix;
  logic signed [W_W-1:0]        w_wt;
  logic signed [PROD_W-1:0]     w_pix_x;
  logic signed [PROD_W-1:0]     w_wt_x;
  logic signed [PROD_W-1:0]     w_prod;
  logic signed [ACC_W-1:0]      w_prod_x;
  logic signed [ACC_W-1:0]      w_sum;
  logic signed [ACC_W-1:0]      w_shift;
  logic [OUT_W-1:0]             w_slot;

  assign w_accept    = (r_state == S_IDLE) && in_valid;
  assign w_release   = (r_state == S_DONE) && out_ready;
  assign w_addr_ok   = (32'(w_addr) < 32'(N_TOT));
  assign w_last_p    = (32'(r_p) == 32'(N_PIX - 1));
  assign w_last_n    = (32'(r_n) == 32'(N_NEUR - 1));

  assign w_widx      = WA_W'(32'(r_n) * 32'(N_PIX) + 32'(r_p));
  assign w_bidx0     = WA_W'(N_W);
  // Guarded so the next-bias index never leaves the table on the last neuron.
  assign w_bidx_next = w_last_n ? w_bidx0 : WA_W'(32'(N_W) + 32'(r_n) + 32'd1);

  assign w_pix       = r_img[32'(r_p) * PIX_W +: PIX_W];
  assign w_wt        = r_w[w_widx];

  // Pixel is unsigned: zero-extend it into the signed product domain.
  assign w_pix_x     = PROD_W'({1'b0, w_pix});
  assign w_wt_x      = PROD_W'(w_wt);
  assign w_prod      = w_pix_x * w_wt_x;
  assign w_prod_x    = ACC_W'(w_prod);
  assign w_sum       = r_acc + w_prod_x;
  assign w_shift     = w_sum >>> SHIFT;

  // Activation and saturation of the finished neuron sum
  always_comb begin
    w_slot = w_shift[OUT_W-1:0];
    if (w_shift > SAT_HI) begin
      w_slot = SAT_HI[OUT_W-1:0];
    end else if (w_shift < SAT_LO) begin
      w_slot = SAT_LO[OUT_W-1:0];
    end
  end

  // Engine FSM: capture image, walk every (neuron, pixel) pair, hold result until taken
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_img       <= '0;
      r_acc       <= '0;
      r_n         <= '0;
      r_p         <= '0;
      r_res       <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_img      <= InputImage;
            r_acc      <= ACC_W'(r_w[w_bidx0]);
            r_n        <= '0;
            r_p        <= '0;
            r_in_ready <= 1'b0;
            r_state    <= S_MAC;
          end
        end
        S_MAC: begin
          if (w_last_p) begin
            r_res[32'(r_n) * OUT_W +: OUT_W] <= w_slot;
            if (w_last_n) begin
              r_out_valid <= 1'b1;
              r_state     <= S_DONE;
            end else begin
              r_n   <= r_n + 1'b1;
              r_p   <= '0;
              r_acc <= ACC_W'(r_w[w_bidx_next]);
            end
          end else begin
            r_acc <= w_sum;
            r_p   <= r_p + 1'b1;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  // Coefficient writes: only in IDLE and in range; a write that coincides with an
  // accept is parked and committed when that image's result is consumed.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_TOT; i++) begin
        r_w[i] <= '0;
      end
      r_cfg_err   <= 1'b0;
      r_pend_v    <= 1'b0;
      r_pend_addr <= '0;
      r_pend_data <= '0;
    end else begin
      r_cfg_err <= 1'b0;
      if (r_pend_v && w_release) begin
        r_w[r_pend_addr] <= r_pend_data;
        r_pend_v         <= 1'b0;
      end
      if (w_we) begin
        if ((r_state == S_IDLE) && w_addr_ok) begin
          if (w_accept) begin
            r_pend_v    <= 1'b1;
            r_pend_addr <= w_addr;
            r_pend_data <= w_data;
          end else begin
            r_w[w_addr] <= w_data;
          end
        end else begin
          r_cfg_err <= 1'b1;
        end
      end
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign cfg_err   = r_cfg_err;
  assign result    = r_res;

endmodule
